// File: rtl/axi_mm_fifo_s2mm_block_if.sv
// AXI4 write channels plus the AXI-Stream input of the stream-to-memory block writer.
// master: the block writer's view; slave: the memory/stream side.
interface axi_mm_fifo_s2mm_block_if #(
    parameter int C_WIDTH = 64,
    parameter int AW      = 27
);
    logic [AW-1:0]      m_axi_awaddr;
    logic [7:0]         m_axi_awlen;
    logic               m_axi_awvalid;
    logic               m_axi_awready;
    logic [C_WIDTH-1:0] m_axi_wdata;
    logic               m_axi_wlast;
    logic               m_axi_wvalid;
    logic               m_axi_wready;
    logic [1:0]         m_axi_bresp;
    logic               m_axi_bvalid;
    logic               m_axi_bready;
    logic [C_WIDTH-1:0] s_axis_tdata;
    logic               s_axis_tlast;
    logic               s_axis_tvalid;
    logic               s_axis_tready;

    modport master (
        output m_axi_awaddr, m_axi_awlen, m_axi_awvalid, input m_axi_awready,
        output m_axi_wdata, m_axi_wlast, m_axi_wvalid, input m_axi_wready,
        input m_axi_bresp, m_axi_bvalid, output m_axi_bready,
        input s_axis_tdata, s_axis_tlast, s_axis_tvalid, output s_axis_tready
    );

    modport slave (
        input m_axi_awaddr, m_axi_awlen, m_axi_awvalid, output m_axi_awready,
        input m_axi_wdata, m_axi_wlast, m_axi_wvalid, output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid, input m_axi_bready,
        output s_axis_tdata, s_axis_tlast, s_axis_tvalid, input s_axis_tready
    );
endinterface

// File: rtl/axi_mm_fifo_s2mm_block.sv
// Writes an AXI-Stream into a ring of fixed-size memory blocks: payload burst first,
// then a two-word header holding per-beat valid and tlast flags.
//
// state          | meaning
// ST_IDLE        | waiting for a full block, a flush or the idle timeout
// ST_ADDR_DATA   | issue AW for the payload burst
// ST_WRITE_DATA  | stream n words, then zero-fill to P beats
// ST_RESP_DATA   | wait for the payload write response
// ST_ADDR_HDR    | issue AW for the header burst
// ST_WRITE_HDR   | write valid flags, then tlast flags
// ST_RESP_HDR    | wait for the header response, advance the ring pointer
module axi_mm_fifo_s2mm_block #(
    parameter int C_WIDTH       = 64,
    parameter int C_BLOCK_WORDS = 64,
    parameter int C_START_ADDR  = 0,
    parameter int C_END_ADDR    = 134217727,
    parameter int C_AVAIL_WIDTH = 16,
    parameter int C_TIMEOUT     = 1024,
    localparam int AW = $clog2(C_END_ADDR + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     flush,
    input  logic                     clear_error,
    input  logic [C_AVAIL_WIDTH-1:0] values_available,
    output logic                     busy,
    output logic [AW-1:0]            mem_ptr,
    output logic                     error,
    output logic [31:0]              blocks_written,
    axi_mm_fifo_s2mm_block_if.master bus
);
    localparam int P   = C_BLOCK_WORDS - 2;
    localparam int BB  = C_BLOCK_WORDS * C_WIDTH / 8;
    localparam int CW  = $clog2(C_BLOCK_WORDS + 1);
    localparam int TW  = $clog2(C_TIMEOUT + 2);
    localparam int AW1 = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR_DATA, ST_WRITE_DATA, ST_RESP_DATA,
        ST_ADDR_HDR, ST_WRITE_HDR, ST_RESP_HDR
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  n_words, beat, n_next;
    logic [P-1:0]   vld_flags, last_flags;
    logic [TW-1:0]  timer;
    logic           flush_pend;
    logic           avail_full, avail_nz, timed_out, start, payload;
    logic           aw_hs, w_hs, b_hs;

    always_comb begin
        avail_full = values_available >= C_AVAIL_WIDTH'(P);
        avail_nz   = values_available != '0;
        timed_out  = (C_TIMEOUT != 0) && (timer == TW'(C_TIMEOUT));
        start      = (state == ST_IDLE) && enable &&
                     (avail_full || (avail_nz && (flush_pend || timed_out)));
        n_next     = avail_full ? CW'(P) : CW'(values_available);
        payload    = beat < n_words;
        aw_hs      = bus.m_axi_awvalid && bus.m_axi_awready;
        w_hs       = bus.m_axi_wvalid && bus.m_axi_wready;
        b_hs       = bus.m_axi_bvalid && bus.m_axi_bready;
        busy       = state != ST_IDLE;
    end

    // Payload beats pass the stream straight through; pad beats and header are sourced here.
    always_comb begin
        bus.m_axi_wvalid  = 1'b0;
        bus.m_axi_wlast   = 1'b0;
        bus.m_axi_wdata   = '0;
        bus.s_axis_tready = 1'b0;
        case (state)
            ST_WRITE_DATA: begin
                bus.m_axi_wlast = beat == CW'(P - 1);
                if (payload) begin
                    bus.m_axi_wvalid  = bus.s_axis_tvalid;
                    bus.m_axi_wdata   = bus.s_axis_tdata;
                    bus.s_axis_tready = bus.m_axi_wready;
                end else begin
                    bus.m_axi_wvalid = 1'b1;
                end
            end
            ST_WRITE_HDR: begin
                bus.m_axi_wvalid = 1'b1;
                bus.m_axi_wlast  = beat == CW'(1);
                bus.m_axi_wdata  = (beat == '0) ? C_WIDTH'(vld_flags) : C_WIDTH'(last_flags);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:       if (start) state_nx = ST_ADDR_DATA;
            ST_ADDR_DATA:  if (aw_hs) state_nx = ST_WRITE_DATA;
            ST_WRITE_DATA: if (w_hs && bus.m_axi_wlast) state_nx = ST_RESP_DATA;
            ST_RESP_DATA:  if (b_hs) state_nx = ST_ADDR_HDR;
            ST_ADDR_HDR:   if (aw_hs) state_nx = ST_WRITE_HDR;
            ST_WRITE_HDR:  if (w_hs && bus.m_axi_wlast) state_nx = ST_RESP_HDR;
            ST_RESP_HDR:   if (b_hs) state_nx = ST_IDLE;
            default:       state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ptr           <= AW'(C_START_ADDR);
            bus.m_axi_awaddr  <= '0;
            bus.m_axi_awlen   <= '0;
            bus.m_axi_awvalid <= 1'b0;
            bus.m_axi_bready  <= 1'b0;
            error             <= 1'b0;
            blocks_written    <= '0;
            timer             <= '0;
            flush_pend        <= 1'b0;
            vld_flags         <= '0;
            last_flags        <= '0;
            n_words           <= '0;
            beat              <= '0;
        end else begin
            if (state == ST_IDLE && enable && avail_nz && !avail_full) begin
                if (!timed_out && timer != TW'(C_TIMEOUT)) timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end

            if (start)                                    flush_pend <= 1'b0;
            else if (flush)                               flush_pend <= 1'b1;
            else if (state == ST_IDLE && !avail_nz)       flush_pend <= 1'b0;

            if (start) n_words <= n_next;

            if (state == ST_ADDR_DATA || state == ST_ADDR_HDR) begin
                if (!bus.m_axi_awvalid) begin
                    bus.m_axi_awvalid <= 1'b1;
                    bus.m_axi_awaddr  <= (state == ST_ADDR_DATA) ? mem_ptr + AW'(2 * C_WIDTH / 8) : mem_ptr;
                    bus.m_axi_awlen   <= (state == ST_ADDR_DATA) ? 8'(P - 1) : 8'd1;
                end else if (bus.m_axi_awready) begin
                    bus.m_axi_awvalid <= 1'b0;
                end
            end

            if (w_hs) beat <= bus.m_axi_wlast ? '0 : beat + CW'(1);

            // Flag bit k-1 describes payload beat k; pad beats record zeros.
            if (state == ST_WRITE_DATA && w_hs) begin
                for (int i = 0; i < P; i++) begin
                    if (beat == CW'(i)) begin
                        vld_flags[i]  <= payload;
                        last_flags[i] <= payload && bus.s_axis_tlast;
                    end
                end
            end

            if (state == ST_RESP_DATA || state == ST_RESP_HDR) begin
                if (!bus.m_axi_bready)     bus.m_axi_bready <= 1'b1;
                else if (bus.m_axi_bvalid) bus.m_axi_bready <= 1'b0;
            end else begin
                bus.m_axi_bready <= 1'b0;
            end

            if (b_hs && bus.m_axi_bresp != 2'b00) error <= 1'b1;
            else if (clear_error)                 error <= 1'b0;

            if (state == ST_RESP_HDR && b_hs) begin
                blocks_written <= blocks_written + 32'd1;
                if ({1'b0, mem_ptr} + AW1'(2 * BB - 1) > AW1'(C_END_ADDR))
                    mem_ptr <= AW'(C_START_ADDR);
                else
                    mem_ptr <= mem_ptr + AW'(BB);
            end
        end
    end
endmodule

// File: tb/tb_axi_mm_fifo_s2mm_block.sv
// Directed bench for the stream-to-memory block writer: a table of block scenarios with
// hand-computed results, plus flush/clear_error/reset corner sequences.
module tb_axi_mm_fifo_s2mm_block;
    localparam int W   = 64;
    localparam int BW  = 64;
    localparam int P   = 62;
    localparam int TO  = 16;
    localparam int END = 32'h3FF;
    localparam int AWD = 10;
    localparam logic [63:0] DATA_BASE = 64'hA5A5_0000_0000_0000;
    localparam int T_FULL = 0, T_TIMEOUT = 1, T_FLUSH = 2, T_ZFLUSH = 3;

    typedef struct {
        int          avail;
        int          trig;
        logic [63:0] tlast_mask;
        bit          stall;
        logic [1:0]  bresp_d;
        logic [1:0]  bresp_h;
        bit          coincide;
        int          exp_n;
        int          exp_start;
        logic [63:0] exp_valid;
        logic [63:0] exp_last;
        int          exp_ptr;
        int          exp_bw;
        bit          exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst, enable, flush, clear_error, busy, error;
    logic [15:0] avail;
    logic [AWD-1:0] mem_ptr;
    logic [31:0] blocks_written;

    int errors = 0, checks = 0;
    int seq = 0, seq0 = 0, src_idx = 0, wl_cnt = 0, b_cnt = 0, coin_cnt = 0, prev_ptr = 0;
    bit stall = 0, coincide = 0, clr_pulse = 0;
    logic [63:0] tlast_mask = '0;
    logic [1:0] bresp_d = 2'b00, bresp_h = 2'b00;
    logic [63:0] aw_addr_q[$], aw_len_q[$], w_data_q[$];
    bit w_last_q[$];
    vec_t vecs[7];

    axi_mm_fifo_s2mm_block_if #(.C_WIDTH(W), .AW(AWD)) bus ();

    axi_mm_fifo_s2mm_block #(
        .C_WIDTH(W), .C_BLOCK_WORDS(BW), .C_START_ADDR(0), .C_END_ADDR(END),
        .C_AVAIL_WIDTH(16), .C_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush), .clear_error(clear_error),
        .values_available(avail), .busy(busy), .mem_ptr(mem_ptr), .error(error),
        .blocks_written(blocks_written), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bail(input string what);
        errors++;
        checks++;
        $display("FAIL %s: wait expired without the expected event", what);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Memory and stream side: records handshakes, checks hold rules, applies stalls.
    initial begin : drv
        logic aw_hs, w_hs, b_hs, t_hs, prev_aw_wait, prev_w_wait;
        logic [AWD-1:0] prev_awaddr;
        logic [63:0] prev_wdata;
        prev_aw_wait = 0; prev_w_wait = 0; prev_awaddr = '0; prev_wdata = '0;
        bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bvalid = 0; bus.m_axi_bresp = 2'b00;
        bus.s_axis_tvalid = 0; bus.s_axis_tdata = '0; bus.s_axis_tlast = 0; clear_error = 0;
        forever begin
            @(negedge clk);
            aw_hs = !rst && bus.m_axi_awvalid && bus.m_axi_awready;
            w_hs  = !rst && bus.m_axi_wvalid && bus.m_axi_wready;
            b_hs  = !rst && bus.m_axi_bvalid && bus.m_axi_bready;
            t_hs  = !rst && bus.s_axis_tvalid && bus.s_axis_tready;
            if (!rst) begin
                if (prev_aw_wait)
                    check("aw_hold", {bus.m_axi_awvalid, bus.m_axi_awaddr}, {1'b1, prev_awaddr});
                if (prev_w_wait)
                    check("w_hold", bus.m_axi_wdata, prev_wdata);
                if (!busy)
                    check("idle_quiet", {bus.m_axi_wvalid, bus.m_axi_wlast, bus.s_axis_tready,
                                         |bus.m_axi_wdata}, 64'd0);
                if (aw_hs) begin
                    aw_addr_q.push_back(64'(bus.m_axi_awaddr));
                    aw_len_q.push_back(64'(bus.m_axi_awlen));
                end
                if (w_hs) begin
                    w_data_q.push_back(bus.m_axi_wdata);
                    w_last_q.push_back(bus.m_axi_wlast);
                    if (bus.m_axi_wlast) wl_cnt++;
                end
                if (b_hs) b_cnt++;
                if (t_hs) begin seq++; src_idx++; end
            end
            prev_aw_wait = !rst && bus.m_axi_awvalid && !bus.m_axi_awready;
            prev_awaddr  = bus.m_axi_awaddr;
            prev_w_wait  = !rst && bus.m_axi_wvalid && !bus.m_axi_wready;
            prev_wdata   = bus.m_axi_wdata;
            @(posedge clk);
            #1;
            if (t_hs || !bus.s_axis_tvalid)
                bus.s_axis_tvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_axis_tdata  = DATA_BASE + 64'(seq);
            bus.s_axis_tlast  = (src_idx < 64) ? tlast_mask[src_idx] : 1'b0;
            bus.m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.m_axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_hs || !bus.m_axi_bvalid) begin
                bus.m_axi_bvalid = (wl_cnt > b_cnt) && (!stall || $urandom_range(0, 1) == 1);
                bus.m_axi_bresp  = (b_cnt == 0) ? bresp_d : bresp_h;
            end
            clear_error = clr_pulse;
            if (coincide && bus.m_axi_bvalid && bus.m_axi_bready && bus.m_axi_bresp != 2'b00) begin
                clear_error = 1'b1;
                coin_cnt++;
            end
            clr_pulse = 0;
        end
    end

    task automatic run_vec(input int i);
        vec_t v;
        int start_i, mism;
        bit done;
        logic [63:0] ev;
        v = vecs[i];
        @(posedge clk); #2;
        aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_last_q.delete();
        wl_cnt = 0; b_cnt = 0; src_idx = 0; seq0 = seq;
        stall = v.stall; tlast_mask = v.tlast_mask; bresp_d = v.bresp_d; bresp_h = v.bresp_h;
        coincide = v.coincide;
        enable = 1;
        if (v.trig == T_ZFLUSH) begin
            avail = 0; flush = 1;
            @(posedge clk); #2; flush = 0;
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_zflush_busy", i), 64'(busy), 64'd0);
            check($sformatf("v%0d_zflush_aw", i), 64'(aw_addr_q.size()), 64'd0);
            @(posedge clk); #2;
        end
        avail = 16'(v.avail);
        if (v.trig == T_FLUSH) flush = 1;
        start_i = 0;
        for (int c = 1; c <= 40 && start_i == 0; c++) begin
            @(posedge clk); #2; flush = 0;
            @(negedge clk);
            if (busy) start_i = c;
        end
        if (start_i == 0) bail($sformatf("v%0d_start", i));
        check($sformatf("v%0d_start_cycle", i), 64'(start_i), 64'(v.exp_start));
        @(posedge clk); #2; enable = 0; avail = 0;
        done = 0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            if (blocks_written == 32'(v.exp_bw)) done = 1;
        end
        if (!done) bail($sformatf("v%0d_block_done", i));
        repeat (2) @(negedge clk);
        check($sformatf("v%0d_aw_count", i), 64'(aw_addr_q.size()), 64'd2);
        if (aw_addr_q.size() == 2) begin
            check($sformatf("v%0d_aw0_addr", i), aw_addr_q[0], 64'(prev_ptr + 16));
            check($sformatf("v%0d_aw0_len", i), aw_len_q[0], 64'd61);
            check($sformatf("v%0d_aw1_addr", i), aw_addr_q[1], 64'(prev_ptr));
            check($sformatf("v%0d_aw1_len", i), aw_len_q[1], 64'd1);
        end
        check($sformatf("v%0d_w_count", i), 64'(w_data_q.size()), 64'd64);
        mism = 0;
        for (int k = 0; k < 64 && k < w_data_q.size(); k++) begin
            if (k < P) begin
                ev = (k < v.exp_n) ? DATA_BASE + 64'(seq0 + k) : 64'd0;
                if (w_data_q[k] !== ev) mism++;
            end
            if (w_last_q[k] != (k == P - 1 || k == P + 1)) mism++;
        end
        check($sformatf("v%0d_payload_mismatches", i), 64'(mism), 64'd0);
        if (w_data_q.size() == 64) begin
            check($sformatf("v%0d_hdr_valid", i), w_data_q[62], v.exp_valid);
            check($sformatf("v%0d_hdr_last", i), w_data_q[63], v.exp_last);
        end
        check($sformatf("v%0d_stream_taken", i), 64'(src_idx), 64'(v.exp_n));
        check($sformatf("v%0d_mem_ptr", i), 64'(mem_ptr), 64'(v.exp_ptr));
        check($sformatf("v%0d_blocks_written", i), 64'(blocks_written), 64'(v.exp_bw));
        check($sformatf("v%0d_error", i), 64'(error), 64'(v.exp_err));
        prev_ptr = v.exp_ptr;
    endtask

    initial begin
        rst = 1; enable = 0; flush = 0; avail = 0;
        //          avail trig       tlast_mask              st bd     bh     co n   st  valid                   last                    ptr    bw err
        vecs[0] = '{62,  T_FULL,    64'h3FFF_FFFF_FFFF_FFFF, 0, 2'b00, 2'b00, 0, 62, 1,  64'h3FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF, 'h200, 1, 0};
        vecs[1] = '{5,   T_TIMEOUT, 64'h10,                  0, 2'b00, 2'b00, 0, 5,  17, 64'h1F,                  64'h10,                  'h000, 2, 0};
        vecs[2] = '{3,   T_FLUSH,   64'h5,                   1, 2'b00, 2'b00, 0, 3,  2,  64'h7,                   64'h5,                   'h200, 3, 0};
        vecs[3] = '{3,   T_ZFLUSH,  64'h4,                   0, 2'b00, 2'b00, 0, 3,  17, 64'h7,                   64'h4,                   'h000, 4, 0};
        vecs[4] = '{100, T_FULL,    64'h2000_0000_0000_0000, 1, 2'b00, 2'b00, 0, 62, 1,  64'h3FFF_FFFF_FFFF_FFFF, 64'h2000_0000_0000_0000, 'h200, 5, 0};
        vecs[5] = '{62,  T_FULL,    64'hF0,                  1, 2'b10, 2'b00, 0, 62, 1,  64'h3FFF_FFFF_FFFF_FFFF, 64'hF0,                  'h000, 6, 1};
        vecs[6] = '{9,   T_FLUSH,   64'h100,                 1, 2'b10, 2'b00, 1, 9,  2,  64'h1FF,                 64'h100,                 'h200, 7, 1};

        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_ptr", 64'(mem_ptr), 64'd0);
        check("rst_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
        check("rst_awaddr_len", {bus.m_axi_awaddr, bus.m_axi_awlen}, 64'd0);
        check("rst_bready", 64'(bus.m_axi_bready), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_blocks_written", 64'(blocks_written), 64'd0);
        check("rst_wvalid_tready", {bus.m_axi_wvalid, bus.s_axis_tready}, 64'd0);
        repeat (3) @(posedge clk);
        #2 rst = 0;

        for (int i = 0; i < 6; i++) run_vec(i);

        @(posedge clk); #2; clr_pulse = 1;
        repeat (3) @(negedge clk);
        check("clear_error", 64'(error), 64'd0);

        run_vec(6);
        check("coincide_hit", 64'(coin_cnt), 64'd1);

        // Reset in the middle of a payload burst.
        @(posedge clk); #2;
        stall = 0; coincide = 0; bresp_d = 2'b00; enable = 1; avail = 62;
        begin
            bit seen;
            seen = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (busy) seen = 1;
            end
            if (!seen) bail("midreset_start");
        end
        repeat (5) @(negedge clk);
        rst = 1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
        check("midrst_wvalid", 64'(bus.m_axi_wvalid), 64'd0);
        check("midrst_mem_ptr", 64'(mem_ptr), 64'd0);
        check("midrst_blocks_written", 64'(blocks_written), 64'd0);
        check("midrst_error", 64'(error), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
